register_command_sequencer: RTL

Command-side driver for the 4-bit shift register. Accepts high-level commands over a valid/ready handshake and drives the register's MODO, ENB, parallel-data and serial-in pins for the required number of clock cycles. The commands are: shift left N, shift right N, parallel load, and hold N. It is the encoder counterpart of the register's mode decoder and sits between the test/control logic and the register.

---
 rtl/register_command_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/register_command_sequencer.sv
// Command sequencer that drives the 4-bit shift register's mode, enable, data and serial-in pins.
// It accepts one shift, load or hold command at a time and runs it for the requested number of enabled cycles.
module register_command_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [CNT_W-1:0] CMD_CNT,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic             CMD_SIN,
  output logic [1:0]       MODO,
  output logic             ENB,
  output logic [WIDTH-1:0] D,
  output logic             S_IN,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_eff;
  logic [1:0]         modo_q, modo_d;
  logic               enb_q, enb_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               s_in_q, s_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Ready is a pure decode of the state register.
  assign CMD_READY = (state_q == ST_IDLE);

  // Next-state and next-output logic; pin values are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    modo_d  = modo_q;
    d_d     = d_q;
    s_in_d  = s_in_q;
    cnt_eff = '0;

    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          cnt_eff = (CMD_OP == OP_LOAD) ? CNT_W'(1) : CMD_CNT;
          cnt_d   = cnt_eff;
          modo_d  = CMD_OP;
          d_d     = CMD_DATA;
          s_in_d  = CMD_SIN;
          state_d = (cnt_eff == '0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        modo_d  = OP_HOLD;
      end
      default: begin
        state_d = ST_IDLE;
        modo_d  = OP_HOLD;
      end
    endcase

    enb_d  = (state_d == ST_ACTIVE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and registered pin outputs; reset abandons any command in flight.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      modo_q  <= OP_HOLD;
      enb_q   <= 1'b0;
      d_q     <= '0;
      s_in_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      modo_q  <= modo_d;
      enb_q   <= enb_d;
      d_q     <= d_d;
      s_in_q  <= s_in_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign MODO = modo_q;
  assign ENB  = enb_q;
  assign D    = d_q;
  assign S_IN = s_in_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
